// File: rtl/seq_pkg.sv
// Shared definitions for the programmable sequence detector: state encoding,
// default sizing and the configuration length legality check.
package seq_pkg;

  localparam int DEF_W  = 8;
  localparam int DEF_CW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b11
  } state_t;

  // A pattern length is usable only when it selects at least one bit and
  // no more bits than the history register can hold.
  function automatic logic len_is_legal(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration bus between a host and the sequence detector: one valid/ready
// transaction carries pattern, length, overlap mode and match threshold.
interface seq_detect_ctrl_if
  import seq_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
);

  localparam int LW = $clog2(W + 1);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          cfg_overlap;
  logic [CW-1:0] cfg_threshold;

  modport master (
    output cfg_valid,
    output cfg_pattern,
    output cfg_len,
    output cfg_overlap,
    output cfg_threshold,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_pattern,
    input  cfg_len,
    input  cfg_overlap,
    input  cfg_threshold,
    output cfg_ready
  );

endinterface

// File: rtl/seq_detect_ctrl_shift_matcher.sv
// Serial history register with fill tracking and a length-masked compare of the
// newest len bits (including the bit arriving this cycle) against the pattern.
module seq_shift_matcher
  import seq_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     clr_fill,
  input  logic                     in,
  input  logic [W-1:0]             pattern,
  input  logic [$clog2(W+1)-1:0]   len,
  output logic                     hit
);

  localparam int LW = $clog2(W + 1);

  logic [W-1:0]  history;
  logic [LW-1:0] fill;
  logic [W-1:0]  window;
  logic [W-1:0]  mask;
  logic [LW:0]   fill_needed;
  logic          fill_ok;

  // The window already contains the incoming bit so a match is reported in
  // the same cycle as the completing bit.
  always_comb begin
    window = {history[W-2:0], in};
    mask   = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (i < int'(len));
    end
    fill_needed = {1'b0, len} - {{LW{1'b0}}, 1'b1};
    fill_ok     = ({1'b0, fill} >= fill_needed);
    hit         = shift_en & fill_ok & ((window & mask) == (pattern & mask));
  end

  // Clearing wins over shifting: after a non-overlapping match the bit that
  // completed it must not count towards the next match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clr_fill) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= window;
      if (fill != LW'(W)) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable Mealy sequence-detection controller: holds the detector
// configuration, sequences scan sessions and counts matches up to a threshold.
module seq_detect_ctrl
  import seq_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detect_ctrl_if.slave     cfg,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic                 in,
  output logic                 q,
  output logic [CW-1:0]        match_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int LW = $clog2(W + 1);

  state_t        state;
  state_t        state_next;

  logic [W-1:0]  pattern_r;
  logic [LW-1:0] len_r;
  logic          overlap_r;
  logic [CW-1:0] threshold_r;
  logic          err_r;

  logic          is_idle;
  logic          is_scan;
  logic          len_ok;
  logic          cfg_accept;
  logic          cfg_reject;
  logic          session_start;
  logic          shift_en;
  logic          clr_fill;
  logic          hit;
  logic [CW:0]   count_inc;
  logic          thr_reached;

  always_comb begin
    is_idle       = (state == IDLE);
    is_scan       = (state == SCAN);
    len_ok        = len_is_legal(int'(cfg.cfg_len), W);
    cfg_accept    = is_idle & cfg.cfg_valid & len_ok;
    cfg_reject    = is_idle & cfg.cfg_valid & ~len_ok;
    session_start = is_idle & start;
    shift_en      = is_scan & in_valid;
    q             = hit & ~abort & is_scan;
    clr_fill      = session_start | (q & ~overlap_r);
    count_inc     = {1'b0, match_count} + {{CW{1'b0}}, 1'b1};
    thr_reached   = q & (threshold_r != '0) & (count_inc == {1'b0, threshold_r});
  end

  seq_shift_matcher #(
    .W (W)
  ) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr_fill (clr_fill),
    .in       (in),
    .pattern  (pattern_r),
    .len      (len_r),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort takes priority over a threshold hit in the same cycle; q is already
  // suppressed by abort, so thr_reached cannot fire then anyway.
  always_comb begin
    state_next    = state;
    cfg.cfg_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        cfg.cfg_ready = 1'b1;
        if (start) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (thr_reached) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A config written together with start is visible to the session because
  // SCAN only begins using the registers on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_r   <= '0;
      len_r       <= LW'(1);
      overlap_r   <= 1'b0;
      threshold_r <= '0;
      err_r       <= 1'b0;
    end else begin
      err_r <= cfg_reject;
      if (cfg_accept) begin
        pattern_r   <= cfg.cfg_pattern;
        len_r       <= cfg.cfg_len;
        overlap_r   <= cfg.cfg_overlap;
        threshold_r <= cfg.cfg_threshold;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
    end else if (session_start) begin
      match_count <= '0;
    end else if (q && (match_count != '1)) begin
      match_count <= match_count + 1'b1;
    end
  end

  assign err = err_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl: overlap modes, threshold,
// input gaps, abort, config rejection and collision, and asynchronous reset.
module tb_seq_detect_ctrl;
  import seq_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in;
  logic          q;
  logic [CW-1:0] match_count;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic          q_s;
  logic          done_s;
  logic          busy_s;
  logic          err_s;
  logic          ready_s;
  logic [CW-1:0] cnt_s;

  seq_detect_ctrl_if #(.W(W), .CW(CW)) cfg_bus ();

  seq_detect_ctrl #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_bus),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in          (in),
    .q           (q),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are captured 1 ns later, so q
  // reflects the new inputs and registered outputs reflect the last rising edge.
  task automatic cyc(input logic cv, input logic st, input logic ab, input logic iv, input logic b);
    @(negedge clk);
    cfg_bus.cfg_valid = cv;
    start = st;
    abort = ab;
    in_valid = iv;
    in = b;
    #1;
    q_s = q;
    done_s = done;
    busy_s = busy;
    err_s = err;
    ready_s = cfg_bus.cfg_ready;
    cnt_s = match_count;
  endtask

  task automatic set_cfg(input logic [W-1:0] p, input logic [3:0] l, input logic ov, input logic [CW-1:0] th);
    cfg_bus.cfg_pattern = p;
    cfg_bus.cfg_len = l;
    cfg_bus.cfg_overlap = ov;
    cfg_bus.cfg_threshold = th;
  endtask

  task automatic test_reset();
    n_checks++; if (q !== 1'b0) begin n_fail++; $display("[TB] FAIL reset q: got %b expected 0", q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (match_count !== 8'd0) begin n_fail++; $display("[TB] FAIL reset count: got %0d expected 0", match_count); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset err: got %b expected 0", err); end
    n_checks++; if (cfg_bus.cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset cfg_ready: got %b expected 1", cfg_bus.cfg_ready); end
  endtask

  task automatic test_overlap_on();
    logic bits [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic expq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, bits[i]);
      n_checks++; if (q_s !== expq[i]) begin n_fail++; $display("[TB] FAIL ovl_on q bit%0d: got %b expected %b", i + 1, q_s, expq[i]); end
      n_checks++; if (busy_s !== 1'b1) begin n_fail++; $display("[TB] FAIL ovl_on busy bit%0d: got %b expected 1", i + 1, busy_s); end
    end
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (cnt_s !== 8'd2) begin n_fail++; $display("[TB] FAIL ovl_on count: got %0d expected 2", cnt_s); end
    n_checks++; if (done_s !== 1'b0) begin n_fail++; $display("[TB] FAIL ovl_on done: got %b expected 0", done_s); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("[TB] FAIL ovl_on abort ready: got %b expected 1", ready_s); end
    n_checks++; if (cnt_s !== 8'd2) begin n_fail++; $display("[TB] FAIL ovl_on retained count: got %0d expected 2", cnt_s); end
  endtask

  task automatic test_overlap_off();
    logic bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic expq [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    set_cfg(8'b101, 4'd3, 1'b0, 8'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, bits[i]);
      n_checks++; if (q_s !== expq[i]) begin n_fail++; $display("[TB] FAIL ovl_off q bit%0d: got %b expected %b", i + 1, q_s, expq[i]); end
    end
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (cnt_s !== 8'd2) begin n_fail++; $display("[TB] FAIL ovl_off count: got %0d expected 2", cnt_s); end
    cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_threshold();
    logic bits [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic expq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    set_cfg(8'b101, 4'd3, 1'b1, 8'd2);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, bits[i]);
      n_checks++; if (q_s !== expq[i]) begin n_fail++; $display("[TB] FAIL thr q bit%0d: got %b expected %b", i + 1, q_s, expq[i]); end
      n_checks++; if (done_s !== 1'b0) begin n_fail++; $display("[TB] FAIL thr early done bit%0d: got %b expected 0", i + 1, done_s); end
    end
    cyc(0, 0, 0, 1, 1);
    n_checks++; if (done_s !== 1'b1) begin n_fail++; $display("[TB] FAIL thr done pulse: got %b expected 1", done_s); end
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("[TB] FAIL thr busy in DONE: got %b expected 0", busy_s); end
    n_checks++; if (q_s !== 1'b0) begin n_fail++; $display("[TB] FAIL thr q in DONE: got %b expected 0", q_s); end
    cyc(0, 0, 0, 1, 0);
    n_checks++; if (done_s !== 1'b0) begin n_fail++; $display("[TB] FAIL thr done width: got %b expected 0", done_s); end
    n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("[TB] FAIL thr back to idle: got %b expected 1", ready_s); end
    cyc(0, 0, 0, 1, 1);
    n_checks++; if (q_s !== 1'b0) begin n_fail++; $display("[TB] FAIL thr q after done: got %b expected 0", q_s); end
    n_checks++; if (cnt_s !== 8'd2) begin n_fail++; $display("[TB] FAIL thr count: got %0d expected 2", cnt_s); end
  endtask

  task automatic test_gaps_abort();
    logic ivs  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic bits [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic expq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, ivs[i], bits[i]);
      n_checks++; if (q_s !== expq[i]) begin n_fail++; $display("[TB] FAIL gaps q step%0d: got %b expected %b", i, q_s, expq[i]); end
    end
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (cnt_s !== 8'd1) begin n_fail++; $display("[TB] FAIL gaps count: got %0d expected 1", cnt_s); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    n_checks++; if (q_s !== 1'b1) begin n_fail++; $display("[TB] FAIL abort pre-match q: got %b expected 1", q_s); end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 1);
    n_checks++; if (q_s !== 1'b0) begin n_fail++; $display("[TB] FAIL abort q suppressed: got %b expected 0", q_s); end
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("[TB] FAIL abort busy: got %b expected 0", busy_s); end
    n_checks++; if (cnt_s !== 8'd1) begin n_fail++; $display("[TB] FAIL abort count: got %0d expected 1", cnt_s); end
    n_checks++; if (done_s !== 1'b0) begin n_fail++; $display("[TB] FAIL abort done: got %b expected 0", done_s); end
  endtask

  task automatic test_bad_cfg_collision();
    set_cfg(8'b11, 4'd0, 1'b1, 8'd0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (err_s !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_cfg err pulse: got %b expected 1", err_s); end
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (err_s !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_cfg err width: got %b expected 0", err_s); end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    n_checks++; if (q_s !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_cfg old pattern q: got %b expected 1", q_s); end
    cyc(0, 0, 1, 0, 0);
    set_cfg(8'b11, 4'd2, 1'b1, 8'd0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    n_checks++; if (q_s !== 1'b0) begin n_fail++; $display("[TB] FAIL collision q bit1: got %b expected 0", q_s); end
    cyc(0, 0, 0, 1, 1);
    n_checks++; if (q_s !== 1'b1) begin n_fail++; $display("[TB] FAIL collision q bit2: got %b expected 1", q_s); end
    set_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    cyc(1, 0, 0, 0, 0);
    n_checks++; if (ready_s !== 1'b0) begin n_fail++; $display("[TB] FAIL scan cfg_ready: got %b expected 0", ready_s); end
    cyc(0, 0, 0, 1, 1);
    n_checks++; if (q_s !== 1'b1) begin n_fail++; $display("[TB] FAIL scan cfg ignored q: got %b expected 1", q_s); end
    cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid_scan();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in = 1'b1;
    #1;
    n_checks++; if (q !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_scan q before reset: got %b expected 1", q); end
    n_checks++; if (match_count !== 8'd1) begin n_fail++; $display("[TB] FAIL mid_scan count before reset: got %0d expected 1", match_count); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (q !== 1'b0) begin n_fail++; $display("[TB] FAIL async reset q: got %b expected 0", q); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL async reset busy: got %b expected 0", busy); end
    n_checks++; if (match_count !== 8'd0) begin n_fail++; $display("[TB] FAIL async reset count: got %0d expected 0", match_count); end
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("[TB] FAIL post reset ready: got %b expected 1", ready_s); end
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    n_checks++; if (q_s !== 1'b1) begin n_fail++; $display("[TB] FAIL reset pattern q on 0: got %b expected 1", q_s); end
    cyc(0, 0, 0, 1, 1);
    n_checks++; if (q_s !== 1'b0) begin n_fail++; $display("[TB] FAIL reset pattern q on 1: got %b expected 0", q_s); end
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (cnt_s !== 8'd1) begin n_fail++; $display("[TB] FAIL reset pattern count: got %0d expected 1", cnt_s); end
    cyc(0, 0, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    set_cfg('0, 4'd1, 1'b0, '0);
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_overlap_on();
    test_overlap_off();
    test_threshold();
    test_gaps_abort();
    test_bad_cfg_collision();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
